mem_reader: RTL

Frame-buffer scan-out engine: reads a full 640×480 frame from the dual-port frame-buffer BRAM read port in raster order and pushes pixels into a downstream output FIFO under almost-full backpressure. It is the read-side counterpart of the FIFO-to-BRAM write path. It sits between the frame-buffer read port and the display/output FIFO. Start-of-frame and end-of-line markers travel alongside each pixel.

---
 rtl/mem_reader_pkg.sv | 37 +++
 rtl/mem_reader_if.sv | 35 +++
 rtl/mem_reader_pipe.sv | 51 +++++
 rtl/mem_reader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mem_reader_pkg.sv
// -----------------------------------------------------------------------------
// mem_reader_pkg
// Shared frame-buffer constants, read-side FSM state encoding and the marker
// tag that travels alongside every pixel read.
//   FB_H_ACTIVE / FB_V_ACTIVE / FB_FRAME_PIXELS : default 640x480 frame geometry
//   FB_ADDR_W                                   : frame-buffer address width (19)
//   FB_DATA_W                                   : default pixel width (12)
//   rd_state_t                                  : IDLE=0, ACTIVE=1, DRAIN=2
//   pix_tag_t                                   : {vld, sof, eol} per pixel read
// -----------------------------------------------------------------------------
package mem_reader_pkg;

   localparam int FB_H_ACTIVE     = 640;
   localparam int FB_V_ACTIVE     = 480;
   localparam int FB_FRAME_PIXELS = FB_H_ACTIVE * FB_V_ACTIVE;
   localparam int FB_ADDR_W       = $clog2(FB_FRAME_PIXELS);
   localparam int FB_DATA_W       = 12;

   // Same numbering as the write-side FSM so both can be decoded alike.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } rd_state_t;

   typedef struct packed {
      logic vld;
      logic sof;
      logic eol;
   } pix_tag_t;

   // Counter width that stays legal for a degenerate count of 1.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_reader_if.sv
// -----------------------------------------------------------------------------
// mem_reader_if
// Bundles the frame-buffer BRAM read port and the output FIFO write port.
//   BRAM side : o_raddr, o_rd_en (reader drives), i_rdata (BRAM drives)
//   FIFO side : o_wr, o_wdata, o_sof, o_eol (reader drives),
//               i_almostfull (FIFO drives)
// Modports: master = scan-out engine, slave = BRAM / FIFO side.
// -----------------------------------------------------------------------------
interface mem_reader_if
   import mem_reader_pkg::*;
#(
   parameter int DATA_WIDTH = FB_DATA_W,
   parameter int AW         = FB_ADDR_W
) ();

   logic [AW-1:0]         o_raddr;
   logic                  o_rd_en;
   logic [DATA_WIDTH-1:0] i_rdata;
   logic                  o_wr;
   logic [DATA_WIDTH-1:0] o_wdata;
   logic                  o_sof;
   logic                  o_eol;
   logic                  i_almostfull;

   modport master (
      output o_raddr, o_rd_en, o_wr, o_wdata, o_sof, o_eol,
      input  i_rdata, i_almostfull
   );

   modport slave (
      input  o_raddr, o_rd_en, o_wr, o_wdata, o_sof, o_eol,
      output i_rdata, i_almostfull
   );

endinterface

// File: rtl/mem_reader_pipe.sv
// -----------------------------------------------------------------------------
// mem_rd_pipe
// Delay line that carries the {vld, sof, eol} tag of each BRAM read for STAGES
// cycles so it lines up with the read data at the tap.
//   CLK  : clock
//   clr  : synchronous clear of the valid bits (reset or flush)
//   push : tag of the read issued this cycle
//   tap  : tag of the read whose data is on the BRAM output this cycle
// -----------------------------------------------------------------------------
module mem_rd_pipe
   import mem_reader_pkg::*;
#(
   parameter int STAGES = 1
) (
   input  logic     CLK,
   input  logic     clr,
   input  pix_tag_t push,
   output pix_tag_t tap
);

   logic [STAGES-1:0] vld_p;
   logic [STAGES-1:0] sof_p;
   logic [STAGES-1:0] eol_p;

   // Stage 0..STAGES-1: valid bits are control and honour the clear
   always_ff @(posedge CLK) begin
      if (clr) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= push.vld;
         for (int i = 1; i < STAGES; i++) begin
            vld_p[i] <= vld_p[i-1];
         end
      end
   end

   // Markers are only looked at when their valid bit is set, so no clear.
   always_ff @(posedge CLK) begin
      sof_p[0] <= push.sof;
      eol_p[0] <= push.eol;
      for (int i = 1; i < STAGES; i++) begin
         sof_p[i] <= sof_p[i-1];
         eol_p[i] <= eol_p[i-1];
      end
   end

   assign tap.vld = vld_p[STAGES-1];
   assign tap.sof = sof_p[STAGES-1];
   assign tap.eol = eol_p[STAGES-1];

endmodule

// File: rtl/mem_reader.sv
// -----------------------------------------------------------------------------
// mem_reader
// Frame-buffer scan-out engine. Reads one frame from the BRAM read port in
// raster order and writes the pixels into the output FIFO, throttled by the
// FIFO almost-full flag. Start-of-frame and end-of-line markers accompany each
// pixel.
//   CLK, RST      : clock, synchronous active-high reset
//   i_flush       : synchronous abort, discards in-flight reads
//   i_start       : frame start request (accepted in IDLE only)
//   o_busy        : FSM not in IDLE
//   o_frame_done  : one-cycle end-of-frame pulse
//   bus (master)  : BRAM read port + FIFO write port, see mem_reader_if
// Build option FB_RD_CONTINUOUS_EN: scan frames back to back without DRAIN;
// o_frame_done then pulses when the read address wraps.
// -----------------------------------------------------------------------------
module mem_reader
   import mem_reader_pkg::*;
#(
   parameter int DATA_WIDTH = FB_DATA_W,
   parameter int BRAM_DEPTH = FB_FRAME_PIXELS,   // multiple of H_ACTIVE
   parameter int H_ACTIVE   = FB_H_ACTIVE,
   parameter int RD_LATENCY = 1                  // 1..3
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         i_flush,
   input  logic         i_start,
   output logic         o_busy,
   output logic         o_frame_done,
   mem_reader_if.master bus
);

   localparam int              AW         = $clog2(BRAM_DEPTH);
   localparam int              CW         = cnt_width(H_ACTIVE);
   localparam logic [AW-1:0]   LAST_ADDR  = AW'(BRAM_DEPTH - 1);
   localparam logic [CW-1:0]   LAST_COL   = CW'(H_ACTIVE - 1);
   localparam logic [1:0]      DRAIN_LAST = 2'(RD_LATENCY);

`ifdef FB_RD_CONTINUOUS_EN
   localparam bit CONT_MODE = 1'b1;
`else
   localparam bit CONT_MODE = 1'b0;
`endif

   rd_state_t       state;
   rd_state_t       state_nxt;
   logic [AW-1:0]   raddr;
   logic [CW-1:0]   col;
   logic [1:0]      drain_cnt;
   logic            rd_en;
   logic            last_rd;
   logic            clr;
   logic            frame_done_q;
   pix_tag_t        push_tag;
   pix_tag_t        tap_tag;
   logic            wr_q;
   logic            sof_q;
   logic            eol_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   // Reset and flush have the same effect; reset simply wins when both occur.
   assign clr     = RST | i_flush;
   assign last_rd = rd_en && (raddr == LAST_ADDR);

   // FSM state register
   always_ff @(posedge CLK) begin
      if (clr) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               state_nxt = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (last_rd && !CONT_MODE) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // RD_LATENCY+1 cycles: enough for the last read to reach o_wr.
            if (drain_cnt == DRAIN_LAST) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: read strobe reacts to almost-full in the same cycle
   always_comb begin
      rd_en  = 1'b0;
      o_busy = 1'b0;
      if (state == ST_ACTIVE) begin
         rd_en = !bus.i_almostfull;
      end
      if (state != ST_IDLE) begin
         o_busy = 1'b1;
      end
   end

   // Raster address and column counters
   always_ff @(posedge CLK) begin
      if (clr) begin
         raddr <= '0;
         col   <= '0;
      end else if (state == ST_IDLE) begin
         if (i_start) begin
            raddr <= '0;
            col   <= '0;
         end
      end else if (rd_en) begin
         raddr <= (raddr == LAST_ADDR) ? '0 : raddr + 1'b1;
         col   <= (col == LAST_COL) ? '0 : col + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (clr || (state != ST_DRAIN)) begin
         drain_cnt <= '0;
      end else begin
         drain_cnt <= drain_cnt + 1'b1;
      end
   end

   // Single-shot: pulse once DRAIN has flushed the last pixel.
   // Continuous: pulse right after the read that wraps the address.
   always_ff @(posedge CLK) begin
      if (clr) begin
         frame_done_q <= 1'b0;
      end else if (CONT_MODE) begin
         frame_done_q <= last_rd;
      end else begin
         frame_done_q <= (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);
      end
   end

   assign push_tag.vld = rd_en;
   assign push_tag.sof = (raddr == '0);
   assign push_tag.eol = (col == LAST_COL);

   mem_rd_pipe #(
      .STAGES (RD_LATENCY)
   ) u_pipe (
      .CLK  (CLK),
      .clr  (clr),
      .push (push_tag),
      .tap  (tap_tag)
   );

   // Output stage: register BRAM data together with its tag
   always_ff @(posedge CLK) begin
      if (clr) begin
         wr_q    <= 1'b0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
         wdata_q <= '0;
      end else begin
         wr_q  <= tap_tag.vld;
         sof_q <= tap_tag.vld & tap_tag.sof;
         eol_q <= tap_tag.vld & tap_tag.eol;
         if (tap_tag.vld) begin
            wdata_q <= bus.i_rdata;
         end
      end
   end

   assign bus.o_raddr   = raddr;
   assign bus.o_rd_en   = rd_en;
   assign bus.o_wr      = wr_q;
   assign bus.o_wdata   = wdata_q;
   assign bus.o_sof     = sof_q;
   assign bus.o_eol     = eol_q;
   assign o_frame_done  = frame_done_q;

endmodule
